// File: rtl/lab8_soc_sysinfo_regs.sv
// System-info Avalon-MM slave: build ID, timestamp, uptime, ms counter,
// CTRL (clear/freeze) and byte-writable scratch regs; 1-cycle read latency.
// Ports: clock, reset (sync, high), address[3:0], read, write,
//   writedata[31:0], byteenable[3:0] -> readdata[31:0], readdatavalid.
module lab8_soc_sysinfo_regs #(
  parameter logic [31:0] SYSTEM_ID   = 32'hCAFE_0001,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned PRESCALE    = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [31:0] PS_MAX = 32'(PRESCALE - 1);
  localparam logic [7:0]  NS8    = 8'(NUM_SCRATCH);

  logic [63:0] uptime;
  logic [31:0] presc;
  logic [31:0] ms_count;
  logic [31:0] hi_shadow;
  logic        freeze;
  logic [31:0] scratch [NUM_SCRATCH];

  logic        a_id, a_ts, a_lo, a_hi;
  logic        a_ms, a_ctrl, a_info;
  logic        ctrl_wr, clear;
  logic [31:0] scr_rd;
  logic [31:0] rd_mux;

  assign a_id   = (address == 4'd0);
  assign a_ts   = (address == 4'd1);
  assign a_lo   = (address == 4'd2);
  assign a_hi   = (address == 4'd3);
  assign a_ms   = (address == 4'd4);
  assign a_ctrl = (address == 4'd5);
  assign a_info = (address == 4'd6);

  assign ctrl_wr = write && a_ctrl && byteenable[0];
  assign clear   = ctrl_wr && writedata[0];

  always_comb begin
    scr_rd = '0;
    for (int k = 0; k < NUM_SCRATCH; k++) begin
      if (address == 4'(8 + k)) scr_rd = scratch[k];
    end
  end

  // Mux uses pre-edge state, so a colliding write is not seen.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      a_id:    rd_mux = SYSTEM_ID;
      a_ts:    rd_mux = TIMESTAMP;
      a_lo:    rd_mux = uptime[31:0];
      a_hi:    rd_mux = hi_shadow;
      a_ms:    rd_mux = ms_count;
      a_ctrl:  rd_mux = {30'd0, freeze, 1'b0};
      a_info:  rd_mux = {24'd0, NS8};
      default: rd_mux = scr_rd;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      uptime        <= '0;
      presc         <= '0;
      ms_count      <= '0;
      hi_shadow     <= '0;
      freeze        <= 1'b0;
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        scratch[k] <= '0;
      end
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
      // Latch high word alongside low word for a tear-free 64-bit read.
      if (read && a_lo) hi_shadow <= uptime[63:32];
      if (ctrl_wr) freeze <= writedata[1];
      if (clear) begin
        uptime   <= '0;
        presc    <= '0;
        ms_count <= '0;
      end else if (!freeze) begin
        uptime <= uptime + 64'd1;
        if (presc == PS_MAX) begin
          presc    <= '0;
          ms_count <= ms_count + 32'd1;
        end else begin
          presc <= presc + 32'd1;
        end
      end
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (write && address == 4'(8 + k)) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
              scratch[k][8*b +: 8] <= writedata[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/lab8_soc_sysinfo_regs.md
# lab8_soc_sysinfo_regs

Parametrised system-information slave on the SoC Avalon-MM interconnect, and the successor to the fixed single-word system-ID peripheral. It exposes a build ID and a build timestamp. It also provides a free-running 64-bit cycle uptime counter with atomic high-word capture, a millisecond counter driven by a prescaler, a control register, and NUM_SCRATCH byte-writable scratch registers. Reads return registered data after one cycle with `readdatavalid`; the slave never stalls.

## Interface
- SYSTEM_ID, default 32'hCAFE_0001: constant returned at word 0
- TIMESTAMP, default 32'd0: build time (Unix seconds), returned at word 1
- NUM_SCRATCH, default 4: scratch register count, legal 1..8
- PRESCALE, default 50000: clock cycles per millisecond tick, legal ≥2
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- address  in  4  word address
- read  in  1  read strobe, one cycle per access
- write  in  1  write strobe, one cycle per access
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes; bit i qualifies writedata[8i+7:8i]
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse qualifying readdata

## Operation
- Word map, with reads at any unlisted address returning 0 and writes there ignored:
  - 0 SYSTEM_ID: read-only.
  - 1 TIMESTAMP: read-only.
  - 2 UPTIME_LO: read-only, uptime[31:0]. A read also loads `hi_shadow` with uptime[63:32] from the same cycle.
  - 3 UPTIME_HI: read-only, returns `hi_shadow`.
  - 4 MS_COUNT: read-only, 32-bit millisecond count; wraps from FFFF_FFFF to 0.
  - 5 CTRL: bit0 CLEAR is write-1-pulse and reads 0. bit1 FREEZE is read/write. Other bits read 0. Writes use byteenable[0].
  - 6 INFO: read-only, {16'h0, PRESCALE-derived 0, 8'h0, NUM_SCRATCH[7:0]}, which means bits [7:0] = NUM_SCRATCH and all other bits 0.
  - 8..8+NUM_SCRATCH-1 SCRATCH[k]: read/write with byte enables.
- Uptime counter (64-bit):
  - Increments by 1 every cycle while FREEZE=0.
  - Wraps from all-ones to 0.
- Prescaler:
  - Counts 0..PRESCALE-1 while FREEZE=0.
  - In the cycle it equals PRESCALE-1, it returns to 0 and MS_COUNT increments.
- CLEAR:
  - Writing CTRL with bit0=1 and byteenable[0]=1 sets uptime, prescaler and MS_COUNT to 0 on the next edge.
  - CLEAR overrides the increment in that cycle.
  - `hi_shadow` and scratch registers are unaffected.
- FREEZE=1 holds uptime, prescaler and MS_COUNT. Clearing FREEZE resumes counting from the held values.
- Read and write in the same cycle (an Avalon protocol violation):
  - The write takes effect.
  - The read returns the pre-write register value.
- An address ≥8+NUM_SCRATCH reads 0, including 8..15 beyond the scratch range.

## Timing
- Read latency: a read sampled high at edge N gives readdata valid and readdatavalid=1 after edge N+1, for exactly one cycle.
- readdata holds its last value until the next read completes.
- Back-to-back reads are sustained at one per cycle with no waitrequest.
- Writes complete at the sampling edge and are visible to a read issued on the following cycle.
- Uptime sampled by a read of word 2 at edge N equals the counter value before edge N's increment.
- Reset values:
  - readdata=0, readdatavalid=0
  - uptime=0, prescaler=0, MS_COUNT=0
  - FREEZE=0, hi_shadow=0
  - all scratch=0
- Reset asserted mid-read drops readdatavalid on the next edge.
- Reset has priority over CLEAR, writes and counting.

## Test plan
- ID and info readback:
  - Stimulus: reset, then read words 0, 1 and 6 back-to-back.
  - Required response: readdatavalid on three consecutive cycles with CAFE_0001, TIMESTAMP, and 0000_0004.
- Atomic uptime capture:
  - Stimulus: force uptime to 0000_0000_FFFF_FFFF via CLEAR plus frozen preload in the bench model, then read word 2 as low=FFFF_FFFF.
  - Required response: a subsequent read of word 3 returns 0 even though the live high word has become 1. Reading word 2 again, then word 3, returns 1.
- Prescaler and milliseconds:
  - Stimulus: PRESCALE=4, reset, wait 13 cycles, then read word 4.
  - Required response: value 3.
  - Stimulus: write CTRL=1, then read word 4 on the next cycle.
  - Required response: 0.
- Freeze:
  - Stimulus: write CTRL=2 at uptime=100, wait 50 cycles, read word 2, then write CTRL=0.
  - Required response: word 2 reads within 1 of the frozen value. Counting resumes afterwards and word 2 increases monotonically.
- Scratch byte enables:
  - Stimulus: write 1234_5678 to word 8 with byteenable=1111, then AABB_CCDD with byteenable=0101.
  - Required response: word 8 reads 12BB_56DD.
  - Stimulus: write to word 12 with NUM_SCRATCH=4.
  - Required response: word 12 reads 0 (no scratch register exists there).
- Reset mid-operation:
  - Stimulus: assert reset in the cycle after a read strobe.
  - Required response: readdatavalid=0 and readdata=0 on the next edge. Scratch and counters read 0 after release.
